// File: rtl/rv32im_muldiv_pkg.sv
// Shared types for the RV32IM multiply/divide unit: FSM states and M-extension funct3 codes.
package rv32im_muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // funct3[2] separates the divide class from the multiply class
  function automatic logic is_div_class(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/rv32im_div_core.sv
// Unsigned restoring radix-2 divider on 32-bit magnitudes.
// Latency: 32 cycles after start; done pulses with final quotient/remainder on the last step.
// Backpressure: none; abort drops the operation, a new start restarts it.
module rv32im_div_core
  import rv32im_muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic        busy;
  logic [4:0]  cnt;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] d;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;

  // remainder stays below the divisor, so the trial difference fits in 33 bits
  always_comb begin
    shifted   = {r, q[31]};
    diff      = shifted - {1'b0, d};
    ge        = ~diff[32];
    remainder = ge ? diff[31:0] : shifted[31:0];
    quotient  = {q[30:0], ge};
    done      = busy && (cnt == 5'd31);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      q    <= '0;
      r    <= '0;
      d    <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      q    <= dividend;
      r    <= '0;
      d    <= divisor;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (busy) begin
      q   <= quotient;
      r   <= remainder;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32im_muldiv_ctrl.sv
// RV32IM M-extension unit: FSM, sign fixup, shift-add multiply (MULDIV_FAST_MUL_EN: one-cycle multiply).
// Latency: o_valid 33 cycles after accept; 1 cycle for b==0, signed overflow, or fast multiply.
// Backpressure: o_ready only in IDLE, o_stall holds IF/ID/EX until the DONE cycle; i_flush kills the op.
module rv32im_muldiv_ctrl
  import rv32im_muldiv_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_val,
  input  logic [31:0] i_rs2_val,
  input  logic        i_flush,
  output logic        o_ready,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_result
);

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic [2:0]  f3_q;
  logic        sa_q, sb_q;

  logic        accept, div_op, special;
  logic        sa_in, sb_in;
  logic [31:0] ma_in, mb_in, special_res;
  logic [32:0] sum33;
  logic [63:0] acc_nxt, mul_prod;
  logic [31:0] mul_res, div_res, q_fix, r_fix;
  logic        div_done;
  logic [31:0] div_q, div_r;

  always_comb begin
    accept = (state == ST_IDLE) && i_valid && !i_flush;
    div_op = is_div_class(i_funct3);
    sa_in  = i_rs1_val[31] && (i_funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
    sb_in  = i_rs2_val[31] && (i_funct3 inside {F3_MULH, F3_DIV, F3_REM});
    ma_in  = sa_in ? (32'd0 - i_rs1_val) : i_rs1_val;
    mb_in  = sb_in ? (32'd0 - i_rs2_val) : i_rs2_val;
    special     = 1'b0;
    special_res = '0;
    if (div_op && i_rs2_val == 32'd0) begin
      special     = 1'b1;
      special_res = i_funct3[1] ? i_rs1_val : 32'hFFFF_FFFF;
    end else if ((i_funct3 == F3_DIV || i_funct3 == F3_REM) &&
                 i_rs1_val == 32'h8000_0000 && i_rs2_val == 32'hFFFF_FFFF) begin
      special     = 1'b1;
      special_res = i_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // acc holds {partial product high, remaining multiplier bits}; one bit retires per cycle
  always_comb begin
    sum33    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
    acc_nxt  = {sum33, acc[31:1]};
    mul_prod = (sa_q ^ sb_q) ? (64'd0 - acc_nxt) : acc_nxt;
    mul_res  = (f3_q == F3_MUL) ? mul_prod[31:0] : mul_prod[63:32];
    q_fix    = (sa_q ^ sb_q) ? (32'd0 - div_q) : div_q;
    r_fix    = sa_q ? (32'd0 - div_r) : div_r;
    div_res  = f3_q[1] ? r_fix : q_fix;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_p;
  logic [31:0]        fast_res;
  always_comb begin
    fast_p   = $signed({sa_in | (sb_in & 1'b0) | (i_rs1_val[31] & (i_funct3 inside {F3_MULH, F3_MULHSU})), i_rs1_val})
             * $signed({i_rs2_val[31] & (i_funct3 == F3_MULH), i_rs2_val});
    fast_res = (i_funct3 == F3_MUL) ? fast_p[31:0] : fast_p[63:32];
  end
  localparam state_t MUL_ENTRY = ST_DONE;
`else
  localparam state_t MUL_ENTRY = ST_MUL;
`endif

  rv32im_div_core u_div (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .start     (accept && div_op && !special),
    .abort     (i_flush),
    .dividend  (ma_in),
    .divisor   (mb_in),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_stall   = 1'b0;
    o_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        o_ready = 1'b1;
        o_stall = i_valid;
        if (accept) begin
          if (div_op) state_nxt = special ? ST_DONE : ST_DIV;
          else        state_nxt = MUL_ENTRY;
        end
      end
      ST_MUL: begin
        o_stall = 1'b1;
        if (i_flush)              state_nxt = ST_IDLE;
        else if (cnt == 5'd31)    state_nxt = ST_DONE;
      end
      ST_DIV: begin
        o_stall = 1'b1;
        if (i_flush)              state_nxt = ST_IDLE;
        else if (div_done)        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_valid   = !i_flush;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      f3_q     <= F3_MUL;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      o_result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3_q  <= i_funct3;
        sa_q  <= sa_in;
        sb_q  <= sb_in;
        cnt   <= '0;
        acc   <= {32'd0, mb_in};
        mcand <= ma_in;
        if (special) o_result <= special_res;
`ifdef MULDIV_FAST_MUL_EN
        else if (!div_op) o_result <= fast_res;
`endif
      end else if (state == ST_MUL && !i_flush) begin
        cnt <= cnt + 5'd1;
        acc <= acc_nxt;
        if (cnt == 5'd31) o_result <= mul_res;
      end else if (state == ST_DIV && !i_flush && div_done) begin
        o_result <= div_res;
      end
    end
  end

endmodule

// File: tb/tb_rv32im_muldiv_ctrl.sv
// Randomized and directed bench for rv32im_muldiv_ctrl against an arithmetic reference model.
module tb_rv32im_muldiv_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_rs1_val = 32'd0;
  logic [31:0] i_rs2_val = 32'd0;
  logic        i_flush = 1'b0;
  logic        o_ready, o_stall, o_valid;
  logic [31:0] o_result;

  rv32im_muldiv_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_funct3  (i_funct3),
    .i_rs1_val (i_rs1_val),
    .i_rs2_val (i_rs2_val),
    .i_flush   (i_flush),
    .o_ready   (o_ready),
    .o_stall   (o_stall),
    .o_valid   (o_valid),
    .o_result  (o_result)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // timing model: busy window [m_lo, m_hi], result strobe at m_done, held output value
  int          m_lo = -1, m_hi = -1, m_done = -1;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_held = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub, sa, sb, p;
    logic        ovf;
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // every-cycle compare against the model
  initial begin
    forever begin
      @(negedge i_clk);
      begin
        logic busy, rdy;
        busy = (cyc >= m_lo) && (cyc <= m_hi);
        rdy  = !busy && (cyc != m_done);
        if (cyc == m_done) m_held = m_res;
        chk("o_ready", {31'd0, o_ready}, {31'd0, rdy});
        chk("o_stall", {31'd0, o_stall}, {31'd0, busy || (rdy && i_valid)});
        chk("o_valid", {31'd0, o_valid}, {31'd0, cyc == m_done});
        chk("o_result", o_result, m_held);
      end
    end
  end

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int flush_at, input int rst_at,
                       input logic lit_en, input logic [31:0] lit, input int lit_lat);
    int lat, acc, vcyc;
    logic killed;
    logic sp;
    sp  = f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    lat = sp ? 1 : (f3[2] ? 33 : MUL_LAT);
    i_funct3 = f3; i_rs1_val = a; i_rs2_val = b; i_valid = 1'b1;
    acc = cyc;
    m_lo = acc + 1; m_hi = acc + lat - 1; m_done = acc + lat;
    m_res = ref_res(f3, a, b);
    vcyc = -1;
    killed = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge i_clk); #1;
      i_funct3  = 3'($urandom);
      i_rs1_val = $urandom;
      i_rs2_val = $urandom;
      i_valid   = (k <= lat) ? 1'($urandom) : 1'b0;
      if (o_valid) vcyc = cyc;
      if (k == flush_at && k < lat) begin
        i_valid = 1'b0; i_flush = 1'b1;
        m_hi = cyc; m_done = -1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        killed = 1'b1;
        break;
      end
      if (k == rst_at && k < lat) begin
        i_valid = 1'b0;
        m_hi = -1; m_done = -1; m_held = 32'd0;
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_async_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_async_stall", {31'd0, o_stall}, 32'd0);
        chk("rst_async_result", o_result, 32'd0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
        killed = 1'b1;
        break;
      end
    end
    if (killed) begin
      for (int k = 0; k < 40; k++) begin
        @(posedge i_clk); #1;
        if (o_valid) vcyc = cyc;
      end
      chk("no_valid_after_kill", 32'(vcyc), 32'hFFFF_FFFF);
    end else if (lit_en) begin
      chk("latency", 32'(vcyc - acc), 32'(lit_lat));
      chk("result_lit", o_result, lit);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_stall", {31'd0, o_stall}, 32'd0);
    chk("reset_result", o_result, 32'd0);
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 1'b1, 32'hFFFF_FFEB, MUL_LAT);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 1'b1, 32'h4000_0000, MUL_LAT);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'hFFFF_FFFE, MUL_LAT);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1, 32'hFFFF_FFFD, 33);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b1, 32'hFFFF_FFFF, 33);
    do_op(3'd5, 32'd100, 32'd7, 0, 0, 1'b1, 32'd14, 33);
    do_op(3'd7, 32'd100, 32'd7, 0, 0, 1'b1, 32'd2, 33);
    do_op(3'd5, 32'd5, 32'd0, 0, 0, 1'b1, 32'hFFFF_FFFF, 1);
    do_op(3'd7, 32'd5, 32'd0, 0, 0, 1'b1, 32'd5, 1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'h8000_0000, 1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1'b1, 32'd0, 1);
    do_op(3'd4, 32'd50, 32'd3, 10, 0, 1'b0, 32'd0, 0);
    do_op(3'd5, 32'd9, 32'd3, 0, 0, 1'b1, 32'd3, 33);
    do_op(3'd0, 32'd12345, 32'd678, 0, 15, 1'b0, 32'd0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int          fl;
      f3 = 3'($urandom);
      a  = pick();
      b  = pick();
      fl = ($urandom % 8 == 0) ? int'($urandom_range(1, 32)) : 0;
      do_op(f3, a, b, fl, 0, 1'b0, 32'd0, 0);
      if ($urandom % 3 == 0) begin
        @(posedge i_clk); #1;
      end
    end

    repeat (2) @(posedge i_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
